// File: rtl/control_unit_if.sv
// Control-unit bundle: datapath status in, datapath control strobes out.
interface control_unit_if;
  logic [2:0] IR;
  logic       Aeq0;
  logic       Apos;
  logic       Enter;
  logic       IRload;
  logic       JMPmux;
  logic       PCload;
  logic       Meminst;
  logic       MemWr;
  logic       Aload;
  logic       Sub;
  logic [1:0] Asel;
  logic       Halt;
  logic [3:0] State;

  // Sequencer side: consumes status, drives controls.
  modport slave (
    input  IR, Aeq0, Apos, Enter,
    output IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt, State
  );

  // Datapath / environment side.
  modport master (
    output IR, Aeq0, Apos, Enter,
    input  IRload, JMPmux, PCload, Meminst, MemWr, Aload, Sub, Asel, Halt, State
  );
endinterface

// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator datapath.
// All control outputs are a combinational decode of the current state,
// qualified by Aeq0/Apos/Enter where a state depends on them.
module control_unit #(
  parameter bit ENTER_EDGE = 1'b1
) (
  input  logic          Clock,
  input  logic          Reset,
  control_unit_if.slave bus
);

  typedef enum logic [3:0] {
    ST_START  = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_LOAD   = 4'd3,
    ST_STORE  = 4'd4,
    ST_ADD    = 4'd5,
    ST_SUB    = 4'd6,
    ST_INPUT  = 4'd7,
    ST_JZ     = 4'd8,
    ST_JPOS   = 4'd9,
    ST_HALT   = 4'd10
  } state_t;

  state_t state;
  state_t state_next;
  logic   enter_q;
  logic   accept;

  // Enter acceptance: rising edge, or plain level when edge mode is off.
  assign accept = ENTER_EDGE ? (bus.Enter & ~enter_q) : bus.Enter;

  // State register and Enter history.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state   <= ST_START;
      enter_q <= 1'b0;
    end else begin
      state   <= state_next;
      enter_q <= bus.Enter;
    end
  end

  // Next-state and control-output decode.
  always_comb begin
    state_next  = ST_START;
    bus.IRload  = 1'b0;
    bus.JMPmux  = 1'b0;
    bus.PCload  = 1'b0;
    bus.Meminst = 1'b0;
    bus.MemWr   = 1'b0;
    bus.Aload   = 1'b0;
    bus.Sub     = 1'b0;
    bus.Asel    = 2'b00;
    bus.Halt    = 1'b0;
    case (state)
      ST_START: state_next = ST_FETCH;
      ST_FETCH: begin
        bus.IRload = 1'b1;
        bus.PCload = 1'b1;
        state_next = ST_DECODE;
      end
      ST_DECODE: begin
        bus.Meminst = 1'b1;
        case (bus.IR)
          3'b000:  state_next = ST_LOAD;
          3'b001:  state_next = ST_STORE;
          3'b010:  state_next = ST_ADD;
          3'b011:  state_next = ST_SUB;
          3'b100:  state_next = ST_INPUT;
          3'b101:  state_next = ST_JZ;
          3'b110:  state_next = ST_JPOS;
          default: state_next = ST_HALT;
        endcase
      end
      ST_LOAD: begin
        bus.Aload  = 1'b1;
        bus.Asel   = 2'b10;
        state_next = ST_FETCH;
      end
      ST_STORE: begin
        bus.Meminst = 1'b1;
        bus.MemWr   = 1'b1;
        state_next  = ST_FETCH;
      end
      ST_ADD: begin
        bus.Aload  = 1'b1;
        state_next = ST_FETCH;
      end
      ST_SUB: begin
        bus.Aload  = 1'b1;
        bus.Sub    = 1'b1;
        state_next = ST_FETCH;
      end
      ST_INPUT: begin
        bus.Asel   = 2'b01;
        bus.Aload  = accept;
        state_next = accept ? ST_FETCH : ST_INPUT;
      end
      ST_JZ: begin
        bus.JMPmux = 1'b1;
        bus.PCload = bus.Aeq0;
        state_next = ST_FETCH;
      end
      ST_JPOS: begin
        bus.JMPmux = 1'b1;
        bus.PCload = bus.Apos;
        state_next = ST_FETCH;
      end
      ST_HALT: begin
        bus.Halt   = 1'b1;
        state_next = ST_HALT;
      end
      default: state_next = ST_START;
    endcase
  end

  assign bus.State = state;

endmodule
